// File: rtl/risc_spm_pkg.sv
// Shared definitions for the memory dump reader: default widths and FSM state encoding.
package risc_spm_pkg;

  localparam int WORD_SIZE = 8;
  localparam int ADDR_SIZE = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mem_dump_reader.sv
// Walks an inclusive (wrapping) address range, reads each memory word and presents
// it with its address on a valid/ready output port; pulses done after the last word.
module mem_dump_reader
  import risc_spm_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int addr_size = ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [addr_size-1:0] first_addr,
  input  logic [addr_size-1:0] last_addr,
  output logic                 mem_rd,
  output logic [addr_size-1:0] mem_addr,
  input  logic [word_size-1:0] mem_data,
  output logic [word_size-1:0] dout,
  output logic [addr_size-1:0] dout_addr,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy,
  output logic                 done
);

  state_t               r_state;
  logic [addr_size-1:0] r_cur_addr;
  logic [addr_size-1:0] r_end_addr;
  logic [addr_size-1:0] r_dout_addr;
  logic [word_size-1:0] r_dout;
  logic                 r_mem_rd;
  logic                 r_dout_valid;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_xfer;
  logic                 w_last;

  assign w_xfer = r_dout_valid && dout_ready;
  assign w_last = (r_cur_addr == r_end_addr);

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values; one-cycle strobes default low each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cur_addr   <= '0;
      r_end_addr   <= '0;
      r_dout_addr  <= '0;
      r_dout       <= '0;
      r_mem_rd     <= 1'b0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_mem_rd <= 1'b0;
      r_done   <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        // Abort beats a simultaneous transfer and suppresses the done pulse.
        r_state      <= ST_IDLE;
        r_dout_valid <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_cur_addr <= first_addr;
              r_end_addr <= last_addr;
              r_mem_rd   <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= ST_READ;
            end
          end
          ST_READ: begin
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            r_dout       <= mem_data;
            r_dout_addr  <= r_cur_addr;
            r_dout_valid <= 1'b1;
            r_state      <= ST_OUT;
          end
          ST_OUT: begin
            if (w_xfer) begin
              r_dout_valid <= 1'b0;
              if (w_last) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_cur_addr <= r_cur_addr + 1'b1;
                r_mem_rd   <= 1'b1;
                r_state    <= ST_READ;
              end
            end
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_cur_addr;
  assign dout       = r_dout;
  assign dout_addr  = r_dout_addr;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench: a word-list model of each dump is compared against the DUT every cycle.
module tb_mem_dump_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, dout_ready;
  logic [7:0] first_addr, last_addr;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] dout, dout_addr;
  logic       dout_valid, busy, done;

  logic [7:0] mem [256];

  // Expected words of the dump in progress and the words actually accepted.
  logic [7:0] exp_addr[$];
  logic [7:0] exp_data[$];
  logic [7:0] got_addr[$];
  logic [7:0] got_data[$];
  logic       exp_done;
  int         rd_cnt, done_cnt;
  int         n_checks, n_pass;

  mem_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data appears the cycle after the read strobe.
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      exp_done = 1'b0;
    end else begin
      check("done", done, exp_done);
      if (done) done_cnt++;
      exp_done = 1'b0;
      if (mem_rd) rd_cnt++;
      if (dout_valid) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_word", dout_valid, 0);
        end else begin
          check("dout_addr", dout_addr, exp_addr[0]);
          check("dout", dout, exp_data[0]);
          if (dout_ready) begin
            got_addr.push_back(dout_addr);
            got_data.push_back(dout);
            void'(exp_addr.pop_front());
            void'(exp_data.pop_front());
            if (exp_addr.size() == 0) exp_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick_n();
    @(negedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [7:0] f, input logic [7:0] l);
    logic [7:0] span;
    logic [7:0] a;
    span = l - f;
    for (int i = 0; i <= int'(span); i++) begin
      a = f + 8'(i);
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
    end
    @(posedge clk); #1;
    start = 1'b1; first_addr = f; last_addr = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin tick_n(); k++; end while (busy && k < 300);
    check({name, "_timeout"}, busy, 0);
    check({name, "_all_words"}, exp_addr.size(), 0);
  endtask

  task automatic wait_got(input int n, input string name);
    int k;
    k = 0;
    while (got_addr.size() < n && k < 100) begin tick_n(); k++; end
    check({name, "_got_timeout"}, (got_addr.size() >= n), 1);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!dout_valid && k < 100) begin tick_n(); k++; end
    check({name, "_valid_timeout"}, dout_valid, 1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_mem_rd"}, mem_rd, 0);
    check({name, "_mem_addr"}, mem_addr, 0);
    check({name, "_dout"}, dout, 0);
    check({name, "_dout_addr"}, dout_addr, 0);
    check({name, "_dout_valid"}, dout_valid, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
  endtask

  initial begin
    int g0, r0, d0;
    logic [7:0] hold_d, hold_a;
    n_checks = 0; n_pass = 0; rd_cnt = 0; done_cnt = 0; exp_done = 1'b0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; dout_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[128] = 8'd6; mem[129] = 8'd1; mem[130] = 8'd2;
    mem[139] = 8'hF0;
    mem[254] = 8'h0A; mem[255] = 8'h0B; mem[0] = 8'h0C; mem[1] = 8'h0D;

    #2 check_zero("reset");
    #10 rst = 1'b1;

    // Basic three-word dump with latency pinned by hand.
    g0 = got_addr.size(); r0 = rd_cnt; d0 = done_cnt;
    start_dump(8'd128, 8'd130);
    tick_n();
    check("lat_mem_rd", mem_rd, 1);
    check("lat_mem_addr", mem_addr, 128);
    tick_n();
    check("lat_no_valid_yet", dout_valid, 0);
    tick_n();
    check("lat_valid", dout_valid, 1);
    check("lat_dout", dout, 6);
    wait_idle("basic");
    check("basic_count", got_addr.size() - g0, 3);
    check("basic_w0", {got_addr[g0], got_data[g0]}, {8'd128, 8'd6});
    check("basic_w1", {got_addr[g0+1], got_data[g0+1]}, {8'd129, 8'd1});
    check("basic_w2", {got_addr[g0+2], got_data[g0+2]}, {8'd130, 8'd2});
    check("basic_reads", rd_cnt - r0, 3);
    check("basic_done", done_cnt - d0, 1);

    // Single word.
    g0 = got_addr.size(); d0 = done_cnt;
    start_dump(8'd139, 8'd139);
    wait_idle("single");
    check("single_count", got_addr.size() - g0, 1);
    check("single_w0", {got_addr[g0], got_data[g0]}, {8'd139, 8'hF0});
    check("single_done", done_cnt - d0, 1);

    // Wrapping range 254..1.
    g0 = got_addr.size();
    start_dump(8'd254, 8'd1);
    wait_idle("wrap");
    check("wrap_count", got_addr.size() - g0, 4);
    check("wrap_addrs", {got_addr[g0], got_addr[g0+1], got_addr[g0+2], got_addr[g0+3]},
          32'hFEFF0001);
    check("wrap_data", {got_data[g0], got_data[g0+1], got_data[g0+2], got_data[g0+3]},
          32'h0A0B0C0D);

    // Consumer stall on the second word.
    g0 = got_addr.size(); r0 = rd_cnt;
    start_dump(8'd16, 8'd18);
    wait_got(g0 + 1, "stall");
    @(posedge clk); #1 dout_ready = 1'b0;
    wait_valid("stall");
    hold_d = dout; hold_a = dout_addr;
    check("stall_addr", hold_a, 17);
    for (int i = 0; i < 5; i++) begin
      tick_n();
      check("stall_valid", dout_valid, 1);
      check("stall_hold", {dout_addr, dout}, {hold_a, hold_d});
    end
    @(posedge clk); #1 dout_ready = 1'b1;
    wait_idle("stall");
    check("stall_reads", rd_cnt - r0, 3);

    // Abort on the second word, then a fresh dump.
    g0 = got_addr.size(); d0 = done_cnt;
    start_dump(8'd40, 8'd45);
    wait_got(g0 + 1, "abort");
    @(posedge clk); #1 dout_ready = 1'b0;
    wait_valid("abort");
    @(posedge clk); #1 abort = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    exp_addr.delete(); exp_data.delete();
    check("abort_valid", dout_valid, 0);
    check("abort_mem_rd", mem_rd, 0);
    check("abort_busy", busy, 0);
    repeat (4) tick_n();
    check("abort_no_done", done_cnt - d0, 0);
    g0 = got_addr.size();
    start_dump(8'd50, 8'd52);
    wait_idle("after_abort");
    check("after_abort_count", got_addr.size() - g0, 3);
    check("after_abort_last", got_addr[g0+2], 52);

    // Asynchronous reset mid-dump.
    start_dump(8'd70, 8'd75);
    repeat (4) tick_n();
    @(posedge clk); #3 rst = 1'b0;
    exp_addr.delete(); exp_data.delete();
    #1 check_zero("mid_reset");
    tick_n();
    #2 rst = 1'b1;
    repeat (3) tick_n();
    check("reset_idle", busy, 0);

    // Start while busy is ignored.
    g0 = got_addr.size(); r0 = rd_cnt;
    start_dump(8'd60, 8'd63);
    tick_n();
    @(posedge clk); #1 start = 1'b1; first_addr = 8'd0; last_addr = 8'd200;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("busy_start");
    check("busy_start_count", got_addr.size() - g0, 4);
    check("busy_start_last", got_addr[g0+3], 63);
    check("busy_start_reads", rd_cnt - r0, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
